// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit logic unit (8 ops) with valid/ready flow control,
// registered zero/ones flags and a saturating count of completed output transfers.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_zero_q, y_zero_d;
  logic             y_ones_q, y_ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_load;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] res;

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    res = a_q;
    case (op_q)
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_NAND: res = ~(a_q & b_q);
      OP_NOR:  res = ~(a_q | b_q);
      OP_XNOR: res = ~(a_q ^ b_q);
      OP_ANDN: res = a_q & ~b_q;
      default: res = a_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      op_d       = op;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // y holds its last value once drained; only out_valid tells the consumer it is stale
  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    y_zero_d   = y_zero_q;
    y_ones_d   = y_ones_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      y_d        = res;
      y_zero_d   = (res == '0);
      y_ones_d   = (res == {WIDTH{1'b1}});
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      y_zero_q   <= 1'b0;
      y_ones_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      y_zero_q   <= y_zero_d;
      y_ones_q   <= y_ones_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign y_zero    = y_zero_q;
  assign y_ones    = y_ones_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: table-driven op vectors plus hand-written
// backpressure, mid-flight reset, counter saturation and bubble sequences.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n;
  logic       in_valid, out_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_ready, out_valid, y_zero, y_ones;
  logic [7:0] y;
  logic [15:0] out_count;
  logic       in_ready2, out_valid2, y_zero2, y_ones2;
  logic [7:0] y2;
  logic [1:0] out_count2;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_zero(y_zero), .y_ones(y_ones), .out_count(out_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .y_zero(y_zero2), .y_ones(y_ones2), .out_count(out_count2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       z;
    logic       o;
  } vec_t;

  vec_t vecs[17];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [7:0] obs_y[$];
  logic       obs_z[$];
  logic       obs_o[$];

  // record each output beat just before the edge on which it transfers
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      obs_y.push_back(y);
      obs_z.push_back(y_zero);
      obs_o.push_back(y_ones);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_y.delete();
    obs_z.delete();
    obs_o.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic drive(input int i);
    a  = vecs[i].a;
    b  = vecs[i].b;
    op = vecs[i].op;
  endtask

  task automatic send(input int i);
    int t = 0;
    drive(i);
    in_valid = 1'b1;
    #1;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) chk("send_timeout", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int t = 0;
    while (obs_y.size() < n && t < 30) begin
      step();
      t++;
    end
  endtask

  task automatic cmp_obs(input int lo, input int hi, input string tag);
    chk({tag, "_beats"}, 32'(obs_y.size()), 32'(hi - lo + 1));
    for (int k = 0; k <= hi - lo && k < obs_y.size(); k++) begin
      chk($sformatf("%s_y%0d", tag, k), 32'(obs_y[k]), 32'(vecs[lo+k].y));
      chk($sformatf("%s_zero%0d", tag, k), 32'(obs_z[k]), 32'(vecs[lo+k].z));
      chk($sformatf("%s_ones%0d", tag, k), 32'(obs_o[k]), 32'(vecs[lo+k].o));
    end
  endtask

  initial begin
    int idx;
    int exp_cnt;
    logic acc;

    vecs[0]  = '{8'hF0, 8'hCC, 3'd0, 8'hC0, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 8'hCC, 3'd1, 8'hFC, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 8'hCC, 3'd2, 8'h3C, 1'b0, 1'b0};
    vecs[3]  = '{8'hF0, 8'hCC, 3'd3, 8'h3F, 1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 8'hCC, 3'd4, 8'h03, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 8'hCC, 3'd5, 8'hC3, 1'b0, 1'b0};
    vecs[6]  = '{8'hF0, 8'hCC, 3'd6, 8'h30, 1'b0, 1'b0};
    vecs[7]  = '{8'hF0, 8'hCC, 3'd7, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 8'hFF, 3'd0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'hFF, 3'd3, 8'hFF, 1'b0, 1'b1};
    vecs[10] = '{8'h01, 8'hFF, 3'd7, 8'h01, 1'b0, 1'b0};
    vecs[11] = '{8'h02, 8'hFF, 3'd7, 8'h02, 1'b0, 1'b0};
    vecs[12] = '{8'h03, 8'hFF, 3'd7, 8'h03, 1'b0, 1'b0};
    vecs[13] = '{8'h11, 8'h0F, 3'd0, 8'h01, 1'b0, 1'b0};
    vecs[14] = '{8'h22, 8'h0F, 3'd2, 8'h2D, 1'b0, 1'b0};
    vecs[15] = '{8'h33, 8'h0F, 3'd4, 8'hC0, 1'b0, 1'b0};
    vecs[16] = '{8'h44, 8'h0F, 3'd6, 8'h40, 1'b0, 1'b0};

    a = '0; b = '0; op = '0;
    rst2_n = 1'b0;
    do_reset();

    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_y", 32'(y), 32'(0));
    chk("rst_flags", 32'({y_zero, y_ones}), 32'(0));
    chk("rst_count", 32'(out_count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    // truth table stream with latency probe on the first two beats
    out_ready = 1'b1;
    send(0);
    chk("lat_not_yet", 32'(out_valid), 32'(0));
    send(1);
    chk("lat_valid", 32'(out_valid), 32'(1));
    chk("lat_y", 32'(y), 32'(8'hC0));
    for (int i = 2; i < 8; i++) send(i);
    wait_obs(8);
    cmp_obs(0, 7, "truth");
    chk("truth_count", 32'(out_count), 32'(8));

    clear_obs();
    send(8);
    send(9);
    wait_obs(2);
    cmp_obs(8, 9, "flags");
    chk("flags_count", 32'(out_count), 32'(10));

    // backpressure: two beats fill the pipe, the third is held off
    do_reset();
    out_ready = 1'b0;
    send(10);
    send(11);
    chk("bp_in_ready_low", 32'(in_ready), 32'(0));
    drive(12);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_hold_ready%0d", k), 32'(in_ready), 32'(0));
      chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'(1));
      chk($sformatf("bp_hold_y%0d", k), 32'(y), 32'(8'h01));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_obs(3);
    repeat (2) step();
    cmp_obs(10, 12, "bp");
    chk("bp_count", 32'(out_count), 32'(3));

    // reset with two beats buffered
    do_reset();
    a = 8'hAA; b = 8'h00; op = 3'd7;
    in_valid = 1'b1;
    step();
    a = 8'hBB;
    step();
    in_valid = 1'b0;
    chk("mid_full", 32'({out_valid, in_ready}), 32'(2'b10));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_out_valid", 32'(out_valid), 32'(0));
    chk("mid_y", 32'(y), 32'(0));
    chk("mid_count", 32'(out_count), 32'(0));
    chk("mid_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;
    repeat (5) step();
    chk("mid_no_ghost", 32'(obs_y.size()), 32'(0));
    chk("mid_valid_stays_low", 32'(out_valid), 32'(0));

    // saturating counter on the CNT_W=2 instance
    rst2_n = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      drive(j % 8);
      in_valid = (j < 6);
      step();
      if (j < 2) exp_cnt = 0;
      else if (j - 1 > 3) exp_cnt = 3;
      else exp_cnt = j - 1;
      chk($sformatf("sat_count%0d", j), 32'(out_count2), 32'(exp_cnt));
    end
    in_valid = 1'b0;

    // bubbles on input, alternating backpressure on output
    do_reset();
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      out_ready = (c % 2 == 1);
      if (c % 2 == 0) begin
        drive(13 + idx);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bub_accepts", 32'(idx), 32'(4));
    wait_obs(4);
    repeat (3) step();
    cmp_obs(13, 16, "bub");
    chk("bub_count", 32'(out_count), 32'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single 2-input AND gate: a WIDTH-bit bitwise logic unit with eight selectable operations.
- Two register stages with valid/ready flow control on input and output, registered result flags, and a saturating completed-transaction counter.
- Sits between a stimulus/operand source and any consumer that can apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1)
- CNT_W, 16, width of the completed-transaction counter (≥1)

Ports:
- clk  input  1  rising-edge clock; only clock in the block
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operand beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select, sampled with a/b
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result this cycle
- y  output  WIDTH  result
- y_zero  output  1  y is all zeros (valid with out_valid)
- y_ones  output  1  y is all ones (valid with out_valid)
- out_count  output  CNT_W  number of completed output transfers, saturating

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset is sampled only on the rising edge of clk with rst_n=0. After that edge:
  - s1_valid=0, s2_valid=0
  - out_valid=0, y=0, y_zero=0, y_ones=0, out_count=0
  - Stage data registers are cleared to 0.
- Reset mid-operation discards all in-flight beats. No output transfer is counted on the reset edge.
- Op encoding:
  - 0 AND a&b
  - 1 OR a|b
  - 2 XOR a^b
  - 3 NAND ~(a&b)
  - 4 NOR ~(a|b)
  - 5 XNOR ~(a^b)
  - 6 ANDN a&~b
  - 7 PASS a
- All op results are exactly WIDTH bits; no undefined op codes exist.
- Stage 1 registers a, b and op on an input transfer (in_valid && in_ready).
- Stage 2 computes the op from the stage-1 registers and registers y, y_zero (y==0) and y_ones (y=={WIDTH{1}}).
- out_valid = s2_valid.
- Flow control:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_load
  - in_ready is combinational from out_ready and state; there is no combinational path from in_valid, a, b or op to any output.
- Latency: with out_ready held 1, a beat accepted at edge N appears on y/out_valid after edge N+1 and transfers at edge N+2. Throughput is 1 beat/cycle.
- Backpressure:
  - With out_ready=0, y, y_zero, y_ones and out_valid hold stable.
  - Stage 1 still accepts one more beat if empty; then in_ready=0.
  - Capacity is 2 beats and no beat is dropped or duplicated.
- Simultaneous load and drain: when stage 2 transfers and stage 1 is valid in the same cycle, stage 2 reloads from stage 1. When a new beat is accepted that same cycle, stage 1 reloads. Otherwise s1_valid clears.
- Stage 2 with out_ready=1 and s1_valid=0: s2_valid clears after the transfer. y retains its last value (don't-care while out_valid=0).
- out_count increments by 1 on each out_valid && out_ready edge. It saturates at 2^CNT_W−1 and never wraps.
- Inputs while in_valid=0 are ignored; a/b/op changes while in_ready=0 have no effect.

Test Plan:
- Reset/truth: WIDTH=8. After reset, hold out_ready=1 and stream a=8'hF0, b=8'hCC with op 0..7 on consecutive cycles.
  - Required: y = C0, FC, 3C, 3F, 03, C3, 30, F0 in order, starting 2 cycles after the first accept.
  - out_count=8. y_zero=0 and y_ones=0 throughout.
- Flags: a=8'h00, b=8'hFF, op=0 -> y=00, y_zero=1. Same operands, op=3 -> y=FF, y_ones=1.
- Backpressure: out_ready=0, offer 3 beats (a=01,02,03; b=FF; op=7).
  - Required: in_ready drops after 2 accepts; y=01 held stable.
  - Raise out_ready -> outputs 01, 02, 03 in order, out_count=3, no loss.
- Reset mid-flight: 2 beats buffered with out_ready=0, assert rst_n=0 for one edge.
  - Required: out_valid=0, y=0, out_count=0, in_ready=1 next cycle.
  - Old beats never appear.
- Saturation: CNT_W=2, stream 6 beats with out_ready=1 -> out_count reads 1, 2, 3, 3, 3, 3.
- Bubble handling: in_valid toggling 1,0,1,0 with out_ready toggling 0,1 -> every accepted beat emerges exactly once, in order, with the correct op result.
